// File: rtl/cv32e40p_pkg.sv
// Shared fault-tolerance definitions: CSR placement, default leaky-bucket settings
// and the operation class encoding used by the redundant execution units.
package cv32e40p_pkg;

    localparam logic [11:0] CSR_FT_ERRBANK_BASE = 12'hB20;

    localparam int unsigned ERROR_THRESHOLD = 8;
    localparam int unsigned ERROR_INCREASE  = 2;
    localparam int unsigned ERROR_DECREASE  = 1;

    typedef enum logic [1:0] {
        FT_CLASS_ALU = 2'd0,
        FT_CLASS_MUL = 2'd1,
        FT_CLASS_DIV = 2'd2,
        FT_CLASS_LSU = 2'd3
    } ft_class_e;

endpackage

// File: rtl/cv32e40p_ft_leaky_counter.sv
// One leaky-bucket error counter with its sticky fault bit; the counter freezes
// once the bit is set and is cleared when software clears the bit.
module cv32e40p_ft_leaky_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 evt,
    input  logic                 err,
    input  logic [CNT_WIDTH-1:0] thr,
    input  logic [3:0]           inc,
    input  logic [3:0]           dec,
    input  logic                 wr_cnt,
    input  logic [CNT_WIDTH-1:0] wdata,
    input  logic                 wr_flt,
    input  logic                 wflt,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 faulty,
    output logic                 new_fault
);

    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] nxt;
    logic                 upd;

    always_comb begin
        sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
        nxt = '0;
        if (err) begin
            nxt = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        end else if (cnt > CNT_WIDTH'(dec)) begin
            nxt = cnt - CNT_WIDTH'(dec);
        end
        upd = evt && !faulty;
        // A CSR access to this slot owns the edge, so the event cannot declare a fault.
        new_fault = upd && !wr_cnt && !wr_flt && (thr != '0) && (nxt >= thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            faulty <= 1'b0;
        end else begin
            if (wr_cnt) begin
                cnt <= wdata;
            end else if (wr_flt && faulty && !wflt) begin
                cnt <= '0;
            end else if (upd) begin
                cnt <= nxt;
            end

            if (wr_flt) begin
                faulty <= wflt;
            end else if (new_fault) begin
                faulty <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_ft_err_counter_bank.sv
// Bank of leaky-bucket error counters per (unit, class) with CSR access to the
// counters, the sticky fault map and a summary status word.
module cv32e40p_ft_err_counter_bank
    import cv32e40p_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 3,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [11:0] CSR_BASE    = CSR_FT_ERRBANK_BASE,
    localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int unsigned NR = NUM_UNITS * NUM_CLASSES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_UNITS-1:0]      valid_i,
    input  logic [NUM_UNITS*CW-1:0]   class_i,
    input  logic [NUM_UNITS-1:0]      error_i,
    input  logic [CNT_WIDTH-1:0]      threshold_i,
    input  logic [3:0]                incr_i,
    input  logic [3:0]                decr_i,
    input  logic [11:0]               csr_addr_i,
    input  logic                      csr_re_i,
    input  logic                      csr_we_i,
    input  logic [31:0]               csr_wdata_i,
    output logic [31:0]               csr_rdata_o,
    output logic                      csr_hit_o,
    output logic [NR-1:0]             perm_faulty_o,
    output logic                      fault_evt_o
);

    localparam int unsigned MAPW = (NR > 32) ? 32 : NR;

    logic [CNT_WIDTH-1:0] cnt_q [NR];
    logic [NR-1:0]        faulty_q;
    logic [NR-1:0]        new_fault;
    logic [NR-1:0]        wr_cnt;
    logic [NR-1:0]        wflt;
    logic [11:0]          off;
    logic [31:0]          off_int;
    logic                 wr;
    logic                 wr_flt;
    logic                 fault_evt_q;
    logic                 unused_wdata;

    assign off       = csr_addr_i - CSR_BASE;
    assign off_int   = 32'(off);
    assign csr_hit_o = (csr_addr_i >= CSR_BASE) && (off_int < NR + 2);
    // Reads win over writes so a read-modify-write race never corrupts state.
    assign wr        = csr_we_i && !csr_re_i && csr_hit_o;
    assign wr_flt    = wr && (off_int == NR);
    assign unused_wdata = ^csr_wdata_i;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
            localparam int unsigned IDX = u * NUM_CLASSES + c;
            logic evt;

            assign evt         = valid_i[u] && (32'(class_i[u*CW +: CW]) == c);
            assign wr_cnt[IDX] = wr && (off_int == IDX);

            if (IDX < 32) begin : g_wmap
                assign wflt[IDX] = csr_wdata_i[IDX];
            end else begin : g_keep
                assign wflt[IDX] = faulty_q[IDX];
            end

            cv32e40p_ft_leaky_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .evt       (evt),
                .err       (error_i[u]),
                .thr       (threshold_i),
                .inc       (incr_i),
                .dec       (decr_i),
                .wr_cnt    (wr_cnt[IDX]),
                .wdata     (csr_wdata_i[CNT_WIDTH-1:0]),
                .wr_flt    (wr_flt),
                .wflt      (wflt[IDX]),
                .cnt       (cnt_q[IDX]),
                .faulty    (faulty_q[IDX]),
                .new_fault (new_fault[IDX])
            );
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (csr_hit_o) begin
            for (int i = 0; i < NR; i++) begin
                if (off_int == i) begin
                    csr_rdata_o = 32'(cnt_q[i]);
                end
            end
            if (off_int == NR) begin
                csr_rdata_o = 32'(faulty_q[MAPW-1:0]);
            end
            if (off_int == NR + 1) begin
                csr_rdata_o = {23'd0, |faulty_q, 8'($countones(faulty_q))};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_evt_q <= 1'b0;
        end else begin
            fault_evt_q <= |new_fault;
        end
    end

    assign fault_evt_o   = fault_evt_q;
    assign perm_faulty_o = faulty_q;

endmodule

// File: tb/tb_cv32e40p_ft_err_counter_bank.sv
// Directed bench for the error counter bank: a 32-bit bank and an 8-bit bank
// share all stimulus; expected values are hand-computed constants.
module tb_cv32e40p_ft_err_counter_bank;
    import cv32e40p_pkg::*;

    localparam logic [11:0] BASE = CSR_FT_ERRBANK_BASE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid;
    logic [5:0]  cls;
    logic [2:0]  error;
    logic [31:0] thr;
    logic [3:0]  incr;
    logic [3:0]  decr;
    logic [11:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [11:0] pf;
    logic        fevt;
    logic [31:0] rdata8;
    logic        hit8;
    logic [11:0] pf8;
    logic        fevt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_ft_err_counter_bank dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .class_i(cls), .error_i(error),
        .threshold_i(thr), .incr_i(incr), .decr_i(decr), .csr_addr_i(addr),
        .csr_re_i(re), .csr_we_i(we), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
        .csr_hit_o(hit), .perm_faulty_o(pf), .fault_evt_o(fevt)
    );

    cv32e40p_ft_err_counter_bank #(.CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .class_i(cls), .error_i(error),
        .threshold_i(thr[7:0]), .incr_i(incr), .decr_i(decr), .csr_addr_i(addr),
        .csr_re_i(re), .csr_we_i(we), .csr_wdata_i(wdata), .csr_rdata_o(rdata8),
        .csr_hit_o(hit8), .perm_faulty_o(pf8), .fault_evt_o(fevt8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0; cls = '0; error = '0; addr = '0; re = 0; we = 0; wdata = '0;
        thr = ERROR_THRESHOLD; incr = 4'(ERROR_INCREASE); decr = 4'(ERROR_DECREASE);
        rst_n = 0;
        #3;
        rst_n = 1;
        tick();
    endtask

    task automatic csr_rd(input int off, output logic [31:0] d, output logic h, output logic [31:0] d8);
        addr = BASE + 12'(off);
        re = 1;
        #1;
        d = rdata; h = hit; d8 = rdata8;
        re = 0;
    endtask

    task automatic csr_wr(input int off, input logic [31:0] d);
        addr = BASE + 12'(off);
        wdata = d;
        we = 1;
        tick();
        we = 0;
    endtask

    task automatic op(input int u, input int c, input logic e);
        valid = '0; error = '0;
        valid[u] = 1'b1;
        error[u] = e;
        cls[u*2 +: 2] = 2'(c);
        tick();
        valid = '0; error = '0;
    endtask

    logic [31:0] d, d8;
    logic        h;

    initial begin
        // 1: reset state and address window
        do_reset();
        check_val("rst_faulty", 32'(pf), 32'h0);
        check_val("rst_evt", 32'(fevt), 32'h0);
        for (int a = 0; a < 14; a++) begin
            csr_rd(a, d, h, d8);
            check_val($sformatf("rst_rd%0d", a), d, 32'h0);
            check_val($sformatf("rst_hit%0d", a), 32'(h), 32'h1);
        end
        csr_rd(14, d, h, d8);
        check_val("hit_out", 32'(h), 32'h0);
        check_val("rd_out", d, 32'h0);

        // 2: saturation into a fault on unit1 class2
        for (int k = 1; k <= 4; k++) begin
            op(1, 2, 1'b1);
            csr_rd(6, d, h, d8);
            check_val($sformatf("u1c2_cnt%0d", k), d, 32'(2 * k));
            check_val($sformatf("u1c2_flt%0d", k), 32'(pf[6]), (k == 4) ? 32'h1 : 32'h0);
            check_val($sformatf("u1c2_evt%0d", k), 32'(fevt), (k == 4) ? 32'h1 : 32'h0);
        end
        tick();
        check_val("evt_one_cycle", 32'(fevt), 32'h0);
        op(1, 2, 1'b1);
        csr_rd(6, d, h, d8);
        check_val("frozen_cnt", d, 32'd8);
        check_val("frozen_evt", 32'(fevt), 32'h0);
        check_val("map_only6", 32'(pf), 32'h40);

        // 3: leak down without underflow
        do_reset();
        for (int k = 0; k < 3; k++) op(0, 0, 1'b1);
        csr_rd(0, d, h, d8);
        check_val("u0c0_up", d, 32'd6);
        for (int k = 0; k < 7; k++) begin
            op(0, 0, 1'b0);
            csr_rd(0, d, h, d8);
            check_val($sformatf("u0c0_dn%0d", k), d, (k < 5) ? 32'(5 - k) : 32'd0);
        end

        // Lowered threshold only bites on the next op of that counter
        do_reset();
        for (int k = 0; k < 3; k++) op(0, 3, 1'b1);
        thr = 4;
        tick();
        check_val("thr_low_nofault", 32'(pf), 32'h0);
        op(0, 3, 1'b0);
        check_val("thr_low_fault", 32'(pf), 32'h8);
        csr_rd(3, d, h, d8);
        check_val("thr_low_cnt", d, 32'd5);

        // 4: 8-bit counter saturates, threshold 0 disables declaration
        do_reset();
        thr = 0;
        csr_wr(0, 32'd254);
        csr_rd(0, d, h, d8);
        check_val("w8_wr", d8, 32'd254);
        op(0, 0, 1'b1);
        csr_rd(0, d, h, d8);
        check_val("w8_sat1", d8, 32'd255);
        op(0, 0, 1'b1);
        csr_rd(0, d, h, d8);
        check_val("w8_sat2", d8, 32'd255);
        check_val("w8_nofault", 32'(pf8), 32'h0);
        check_val("w32_nosat", d, 32'd258);

        // 5: counter write beats same-cycle event, other unit unaffected
        do_reset();
        addr = BASE + 12'd9; wdata = 32'h3; we = 1;
        valid = 3'b101; error = 3'b101; cls = 6'b01_00_01;
        tick();
        we = 0; valid = '0; error = '0;
        csr_rd(9, d, h, d8);
        check_val("wr_over_evt", d, 32'd3);
        csr_rd(1, d, h, d8);
        check_val("other_unit", d, 32'd2);

        // Read wins over write
        addr = BASE + 12'd1; wdata = 32'h77; we = 1; re = 1;
        tick();
        we = 0; re = 0;
        csr_rd(1, d, h, d8);
        check_val("rd_prio", d, 32'd2);

        // 6: clear a fault through the map
        do_reset();
        for (int k = 0; k < 4; k++) op(1, 2, 1'b1);
        tick();
        csr_rd(13, d, h, d8);
        check_val("status_set", d, 32'h101);
        csr_rd(12, d, h, d8);
        check_val("map_set", d, 32'h40);
        csr_wr(12, 32'h0);
        check_val("clr_faulty", 32'(pf), 32'h0);
        check_val("clr_noevt", 32'(fevt), 32'h0);
        csr_rd(6, d, h, d8);
        check_val("clr_cnt", d, 32'h0);
        csr_rd(13, d, h, d8);
        check_val("status_clr", d, 32'h0);

        // Map write sets bits silently; status stays read-only
        csr_wr(12, 32'h201);
        check_val("set_noevt", 32'(fevt), 32'h0);
        check_val("set_map", 32'(pf), 32'h201);
        csr_wr(13, 32'hFFFF_FFFF);
        csr_rd(13, d, h, d8);
        check_val("status_ro", d, 32'h102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
